// File: rtl/qspi_pkg.sv
// Shared opcodes and FSM state encoding for the quad-SPI memory responder.
package qspi_pkg;

  localparam logic [7:0] OP_QUAD_READ  = 8'hEB;
  localparam logic [7:0] OP_QUAD_WRITE = 8'h38;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } qspi_state_t;

endpackage

// File: rtl/qspi_sync.sv
// Two-flop synchronizers for the QSPI pins plus sck/ce_n edge detection in the clk domain.
module qspi_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sck,
  input  logic       i_ce_n,
  input  logic [3:0] i_sio,
  output logic       o_sck_rise,
  output logic       o_sck_fall,
  output logic       o_ce_fall,
  output logic       o_ce_n,
  output logic [3:0] o_sio
);

  logic       r_sck_meta, r_sck_sync, r_sck_prev;
  logic       r_ce_meta, r_ce_sync, r_ce_prev;
  logic [3:0] r_sio_meta, r_sio_sync;

  // ce_n resets high so a device held deselected never sees a false select edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_ce_meta  <= 1'b1;
      r_ce_sync  <= 1'b1;
      r_ce_prev  <= 1'b1;
      r_sio_meta <= 4'h0;
      r_sio_sync <= 4'h0;
    end else begin
      r_sck_meta <= i_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_ce_meta  <= i_ce_n;
      r_ce_sync  <= r_ce_meta;
      r_ce_prev  <= r_ce_sync;
      r_sio_meta <= i_sio;
      r_sio_sync <= r_sio_meta;
    end
  end

  assign o_sck_rise = r_sck_sync & ~r_sck_prev;
  assign o_sck_fall = ~r_sck_sync & r_sck_prev;
  assign o_ce_fall  = ~r_ce_sync & r_ce_prev;
  assign o_ce_n     = r_ce_sync;
  assign o_sio      = r_sio_sync;

endmodule

// File: rtl/qspi_responder.sv
// Quad-SPI target bridging 0xEB quad reads and 0x38 quad writes onto a simple
// byte-wide request/acknowledge memory port, with a one-byte read prefetch buffer.
module qspi_responder
  import qspi_pkg::*;
#(
  parameter int DUMMY_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        ce_n,
  input  logic [3:0]  sio_i,
  output logic [3:0]  sio_o,
  output logic        sio_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output qspi_state_t dbg_state
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  logic       w_sck_rise, w_sck_fall, w_ce_fall, w_ce_n;
  logic [3:0] w_sio;

  qspi_sync u_sync (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sck      (sck),
    .i_ce_n     (ce_n),
    .i_sio      (sio_i),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_ce_fall  (w_ce_fall),
    .o_ce_n     (w_ce_n),
    .o_sio      (w_sio)
  );

  qspi_state_t r_state;
  logic [7:0]  r_cnt;
  logic [19:0] r_shift;
  logic [23:0] r_addr;
  logic        r_is_read;
  logic        r_nib_phase;
  logic [3:0]  r_hi_nib;
  logic [3:0]  r_lo_nib;
  logic [7:0]  r_buf;
  logic        r_buf_valid;
  logic        r_rd_live;
  logic        r_req_due;
  logic [3:0]  r_sio_o;
  logic        r_sio_en;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [23:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_err;

  // Memory handshake: mem_req is a valid that stays high, with mem_addr/mem_we/
  // mem_wdata frozen, until the first cycle mem_ack=1; mem_req drops the cycle after.
  logic       w_rd_cap;
  logic [7:0] w_next_byte;
  logic       w_underrun;
  logic [23:0] w_addr_full;

  assign w_rd_cap    = mem_ack & r_mem_req & ~r_mem_we & r_rd_live;
  assign w_addr_full = {r_shift, w_sio};

  // A byte acked in the same cycle as the boundary bypasses the buffer.
  always_comb begin
    w_next_byte = 8'hFF;
    w_underrun  = 1'b1;
    if (r_buf_valid) begin
      w_next_byte = r_buf;
      w_underrun  = 1'b0;
    end else if (w_rd_cap) begin
      w_next_byte = mem_rdata;
      w_underrun  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_shift     <= 20'd0;
      r_addr      <= 24'd0;
      r_is_read   <= 1'b0;
      r_nib_phase <= 1'b0;
      r_hi_nib    <= 4'h0;
      r_lo_nib    <= 4'h0;
      r_buf       <= 8'h00;
      r_buf_valid <= 1'b0;
      r_rd_live   <= 1'b0;
      r_req_due   <= 1'b0;
      r_sio_o     <= 4'h0;
      r_sio_en    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 24'd0;
      r_mem_wdata <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      if (r_mem_req && mem_ack) r_mem_req <= 1'b0;
      if (w_rd_cap) begin
        r_buf       <= mem_rdata;
        r_buf_valid <= 1'b1;
      end
      if (r_req_due && !r_mem_req) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= r_addr;
        r_addr     <= r_addr + 24'd1;
        r_req_due  <= 1'b0;
      end

      if (r_state != IDLE && w_ce_n) begin
        r_state     <= IDLE;
        r_sio_en    <= 1'b0;
        r_cnt       <= 8'd0;
        r_nib_phase <= 1'b0;
        r_rd_live   <= 1'b0;
        r_buf_valid <= 1'b0;
        r_req_due   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ce_fall) begin
              r_state     <= CMD;
              r_err       <= 1'b0;
              r_cnt       <= 8'd0;
              r_nib_phase <= 1'b0;
            end
          end
          CMD: begin
            if (w_sck_rise) begin
              r_shift <= {r_shift[15:0], w_sio};
              r_cnt   <= r_cnt + 8'd1;
              if (r_cnt == 8'd1) begin
                r_cnt <= 8'd0;
                if ({r_shift[3:0], w_sio} == OP_QUAD_READ) begin
                  r_is_read <= 1'b1;
                  r_state   <= ADDR;
                end else if ({r_shift[3:0], w_sio} == OP_QUAD_WRITE) begin
                  r_is_read <= 1'b0;
                  r_state   <= ADDR;
                end else begin
                  r_state <= IGNORE;
                end
              end
            end
          end
          ADDR: begin
            if (w_sck_rise) begin
              r_shift <= {r_shift[15:0], w_sio};
              r_cnt   <= r_cnt + 8'd1;
              if (r_cnt == 8'd5) begin
                r_cnt       <= 8'd0;
                r_addr      <= w_addr_full;
                r_nib_phase <= 1'b0;
                if (r_is_read) begin
                  r_req_due <= 1'b1;
                  r_rd_live <= 1'b1;
                  r_state   <= (DUMMY_CYCLES == 0) ? RDATA : DUMMY;
                  r_sio_en  <= (DUMMY_CYCLES == 0);
                end else begin
                  r_state <= WDATA;
                end
              end
            end
          end
          DUMMY: begin
            if (w_sck_rise) begin
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt == DUMMY_LAST) begin
                r_state  <= RDATA;
                r_sio_en <= 1'b1;
              end
            end
          end
          RDATA: begin
            if (w_sck_fall) begin
              if (!r_nib_phase) begin
                r_sio_o     <= w_next_byte[7:4];
                r_lo_nib    <= w_next_byte[3:0];
                r_buf_valid <= r_buf_valid & w_rd_cap;
                r_req_due   <= 1'b1;
                r_nib_phase <= 1'b1;
                if (w_underrun) r_err <= 1'b1;
              end else begin
                r_sio_o     <= r_lo_nib;
                r_nib_phase <= 1'b0;
              end
            end
          end
          WDATA: begin
            if (w_sck_rise) begin
              if (!r_nib_phase) begin
                r_hi_nib    <= w_sio;
                r_nib_phase <= 1'b1;
              end else begin
                r_nib_phase <= 1'b0;
                r_addr      <= r_addr + 24'd1;
                // A byte arriving while the previous write is still outstanding is lost.
                if (r_mem_req) begin
                  r_err <= 1'b1;
                end else begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_addr;
                  r_mem_wdata <= {r_hi_nib, w_sio};
                end
              end
            end
          end
          IGNORE: begin
            r_sio_en <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sio_o     = r_sio_o;
  assign sio_en    = r_sio_en;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_qspi_responder.sv
// Directed bench for qspi_responder: a QSPI initiator driver, a request/ack memory
// model with programmable latency, and a scoreboard of expected memory writes.
module tb_qspi_responder;
  import qspi_pkg::*;

  localparam int DUMMY = 6;
  localparam int HALF  = 6;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sck = 1'b0;
  logic        ce_n = 1'b1;
  logic [3:0]  sio_i = 4'h0;
  logic [3:0]  sio_o;
  logic        sio_en;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  logic        err;
  qspi_state_t dbg_state;

  qspi_responder #(.DUMMY_CYCLES(DUMMY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .ce_n      (ce_n),
    .sio_i     (sio_i),
    .sio_o     (sio_o),
    .sio_en    (sio_en),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  logic        ack_hold  = 1'b0;
  int          ack_delay = 1;
  int          ack_cnt   = 0;
  logic [31:0] got_q[$];
  int          req_cycles = 0;
  int          en_cycles  = 0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000010: return 8'h12;
      24'h000011: return 8'h34;
      default:    return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always begin
    @(negedge clk);
    if (mem_req) req_cycles++;
    if (sio_en) en_cycles++;
    if (mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req && !ack_hold) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        ack_cnt = 0;
        if (mem_we) got_q.push_back({mem_addr, mem_wdata});
        else mem_rdata = mem_byte(mem_addr);
      end
    end else if (!mem_req) begin
      ack_cnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int got_base = 0;
  int n_tests  = 0;
  int n_fail   = 0;
  int en_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (mem_req && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_drain"}, 32'(mem_req), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    wait_idle(tag);
    check_eq({tag, "_count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_base < got_q.size()) begin
      check_eq({tag, "_entry"}, got_q[got_base], exp_q.pop_front());
      got_base++;
    end
    exp_q.delete();
    got_base = got_q.size();
  endtask

  // ---------------- driver tasks ----------------
  task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] got, output logic en);
    sio_i = nib;
    repeat (HALF) @(negedge clk);
    got = sio_o;
    en  = sio_en;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_nibbles(input logic [31:0] val, input int n);
    logic [3:0] g;
    logic e;
    for (int i = n - 1; i >= 0; i--) begin
      sck_cycle(val[4*i +: 4], g, e);
      if (e) en_bad++;
    end
  endtask

  task automatic start_txn();
    ce_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic end_txn();
    sck  = 1'b0;
    ce_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic write_txn(input logic [23:0] addr, input logic [15:0] data, input int nbytes);
    en_bad = 0;
    start_txn();
    send_nibbles(32'h38, 2);
    send_nibbles({8'h00, addr}, 6);
    send_nibbles({16'h0, data}, 2 * nbytes);
    end_txn();
  endtask

  task automatic read_txn(input logic [23:0] addr, output logic [15:0] data,
                          output logic [3:0] en_mask, output logic err_start,
                          output logic err_end);
    logic [3:0] g;
    logic e;
    en_bad  = 0;
    data    = 16'h0;
    en_mask = 4'h0;
    start_txn();
    err_start = err;
    send_nibbles(32'hEB, 2);
    send_nibbles({8'h00, addr}, 6);
    send_nibbles(32'h0, DUMMY);
    for (int i = 0; i < 4; i++) begin
      sck_cycle(4'h0, g, e);
      data    = {data[11:0], g};
      en_mask = {en_mask[2:0], e};
    end
    err_end = err;
    end_txn();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] rd;
    logic [3:0]  enm;
    logic        e0, e1;
    int          snap_req, snap_en;

    repeat (3) @(negedge clk);
    check_eq("rst_sio_en",    32'(sio_en),    32'd0);
    check_eq("rst_sio_o",     32'(sio_o),     32'd0);
    check_eq("rst_mem_req",   32'(mem_req),   32'd0);
    check_eq("rst_mem_we",    32'(mem_we),    32'd0);
    check_eq("rst_mem_addr",  32'(mem_addr),  32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_err",       32'(err),       32'd0);
    check_eq("rst_state",     32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic two-byte write, ack two cycles after request
    ack_delay = 2;
    exp_q.push_back({24'h000100, 8'hA5});
    exp_q.push_back({24'h000101, 8'h3C});
    write_txn(24'h000100, 16'hA53C, 2);
    check_writes("wr_basic");
    check_eq("wr_basic_err", 32'(err), 32'd0);
    check_eq("wr_sio_en", 32'(en_bad), 32'd0);

    // quad read of two bytes, one-cycle ack
    ack_delay = 1;
    read_txn(24'h000010, rd, enm, e0, e1);
    check_eq("rd_data", 32'(rd), 32'h1234);
    check_eq("rd_en_data", 32'(enm), 32'hF);
    check_eq("rd_en_pre", 32'(en_bad), 32'd0);
    check_eq("rd_err", 32'(e1), 32'd0);
    check_eq("rd_en_after", 32'(sio_en), 32'd0);
    wait_idle("rd");

    // address wrap at the top of the 24-bit space
    exp_q.push_back({24'hFFFFFF, 8'h11});
    exp_q.push_back({24'h000000, 8'h22});
    write_txn(24'hFFFFFF, 16'h1122, 2);
    check_writes("wr_wrap");

    // unsupported opcode is ignored
    snap_req = req_cycles;
    snap_en  = en_cycles;
    start_txn();
    send_nibbles(32'h9F, 2);
    send_nibbles(32'h12345678, 8);
    check_eq("ign_state", 32'(dbg_state), 32'(IGNORE));
    end_txn();
    check_eq("ign_no_req", 32'(req_cycles - snap_req), 32'd0);
    check_eq("ign_no_en", 32'(en_cycles - snap_en), 32'd0);
    check_eq("ign_idle", 32'(dbg_state), 32'(IDLE));

    // write aborted mid-address, then a clean write
    snap_req = req_cycles;
    start_txn();
    send_nibbles(32'h38, 2);
    send_nibbles(32'h000, 3);
    end_txn();
    check_eq("abort_no_req", 32'(req_cycles - snap_req), 32'd0);
    check_eq("abort_idle", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back({24'h000400, 8'h5A});
    write_txn(24'h000400, 16'h005A, 1);
    check_writes("wr_after_abort");

    // read underrun: memory never answers during the transfer
    ack_hold = 1'b1;
    read_txn(24'h000020, rd, enm, e0, e1);
    check_eq("ur_byte0", 32'(rd[15:8]), 32'hFF);
    check_eq("ur_err", 32'(e1), 32'd1);
    ack_hold = 1'b0;
    wait_idle("ur_late_ack");
    repeat (4) @(negedge clk);
    check_eq("ur_err_sticky", 32'(err), 32'd1);

    // next transaction clears err; late ack from the aborted read must not leak in
    read_txn(24'h000010, rd, enm, e0, e1);
    check_eq("ur_err_clear", 32'(e0), 32'd0);
    check_eq("rd2_data", 32'(rd), 32'h1234);
    check_eq("rd2_err", 32'(e1), 32'd0);
    wait_idle("rd2");

    // reset while a write request waits for its ack
    ack_hold = 1'b1;
    start_txn();
    send_nibbles(32'h38, 2);
    send_nibbles(32'h000500, 6);
    send_nibbles(32'h66, 2);
    repeat (4) @(negedge clk);
    check_eq("rst_req_pending", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_req_drop", 32'(mem_req), 32'd0);
    check_eq("rst_addr_clr", 32'(mem_addr), 32'd0);
    ce_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n    = 1'b1;
    ack_hold = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_no_write", 32'(got_q.size() - got_base), 32'd0);
    check_eq("rst_state_idle", 32'(dbg_state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
